// File: rtl/iopmp_pkg.sv
// iopmp_pkg: register offsets and shared types for the iopmp configuration port.
package iopmp_pkg;
    localparam logic [31:0] IOPMP_CTL_OFF        = 32'h0000_0004;
    localparam logic [31:0] IOPMP_MDMASK_OFF     = 32'h0000_0008;
    localparam logic [31:0] IOPMP_RCD_OFF        = 32'h0000_0010;
    localparam logic [31:0] IOPMP_RCD_ADDR_OFF   = 32'h0000_0018;
    localparam logic [31:0] IOPMP_SRCMD_OFF      = 32'h0000_1000;
    localparam logic [31:0] IOPMP_ENTRY_ADDR_OFF = 32'h0000_2000;
    localparam logic [31:0] IOPMP_ENTRY_CFG_OFF  = 32'h0000_2008;
    localparam int RCD_ILLCGT_BIT = 31;
    typedef enum logic [2:0] {
        BOOT, IDLE, HOST, RD_RCD, RD_ADDR, CLR, DONE_HOLD
    } iopmp_cfg_ctrl_state_t;
endpackage

// File: rtl/iopmp_cfg_port_drv.sv
// iopmp_cfg_port_drv: registers one config command per cycle onto the port and
// returns the sampled read data one cycle after the access.
module iopmp_cfg_port_drv #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0] IOPMP_BASE = ADDR_WIDTH'(32'h5000_0000)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    input  logic                  cmd_we_i,
    input  logic                  cmd_tag_i,
    input  logic [ADDR_WIDTH-1:0] cmd_off_i,
    input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
    output logic [ADDR_WIDTH-1:0] address_cfg,
    output logic                  en_cfg,
    output logic                  we_cfg,
    output logic [DATA_WIDTH-1:0] wdata_cfg,
    input  logic [DATA_WIDTH-1:0] rdata_cfg,
    output logic                  rd_valid_o,
    output logic                  rd_tag_o,
    output logic [DATA_WIDTH-1:0] rd_data_o
);
    logic tag_q;
    logic rd_now;

    assign rd_now = en_cfg & ~we_cfg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            address_cfg <= '0;
            en_cfg      <= 1'b0;
            we_cfg      <= 1'b0;
            wdata_cfg   <= '0;
            tag_q       <= 1'b0;
            rd_valid_o  <= 1'b0;
            rd_tag_o    <= 1'b0;
            rd_data_o   <= '0;
        end else begin
            address_cfg <= cmd_valid_i ? IOPMP_BASE + cmd_off_i : '0;
            en_cfg      <= cmd_valid_i;
            we_cfg      <= cmd_valid_i & cmd_we_i;
            wdata_cfg   <= cmd_valid_i ? cmd_wdata_i : '0;
            tag_q       <= cmd_valid_i & cmd_tag_i;
            rd_valid_o  <= rd_now;
            rd_tag_o    <= rd_now & tag_q;
            rd_data_o   <= rd_now ? rdata_cfg : rd_data_o;
        end
    end
endmodule

// File: rtl/iopmp_cfg_ctrl.sv
// iopmp_cfg_ctrl: boots the iopmp from a table, then arbitrates host accesses
// against a violation-record drainer on the single configuration port.
module iopmp_cfg_ctrl
    import iopmp_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0] IOPMP_BASE = ADDR_WIDTH'(32'h5000_0000),
    parameter int TBL_IDX_W = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic [TBL_IDX_W-1:0]  tbl_idx_o,
    input  logic [ADDR_WIDTH-1:0] tbl_off_i,
    input  logic [DATA_WIDTH-1:0] tbl_data_i,
    input  logic                  tbl_last_i,
    output logic                  boot_done_o,
    output logic                  boot_err_o,
    input  logic                  host_req_i,
    input  logic                  host_we_i,
    input  logic [ADDR_WIDTH-1:0] host_off_i,
    input  logic [DATA_WIDTH-1:0] host_wdata_i,
    output logic                  host_gnt_o,
    output logic                  host_rvalid_o,
    output logic [DATA_WIDTH-1:0] host_rdata_o,
    input  logic                  viol_i,
    output logic                  irq_o,
    input  logic                  irq_ack_i,
    output logic [31:0]           rec_rcd_o,
    output logic [DATA_WIDTH-1:0] rec_addr_o,
    output logic [7:0]            ovf_cnt_o,
    output logic [ADDR_WIDTH-1:0] address_cfg,
    output logic                  en_cfg,
    output logic                  we_cfg,
    output logic [DATA_WIDTH-1:0] wdata_cfg,
    input  logic [DATA_WIDTH-1:0] rdata_cfg
);
    iopmp_cfg_ctrl_state_t state, state_n;
    logic                  busy, busy_n;
    logic                  viol_pend;
    logic [DATA_WIDTH-1:0] host_rdata_q;
    logic                  cmd_valid, cmd_we, cmd_tag;
    logic [ADDR_WIDTH-1:0] cmd_off;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rd_valid, rd_tag;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wrap, boot_end, drain_go, drv_done, drain_end;

    assign wrap          = (&tbl_idx_o) & ~tbl_last_i;
    assign boot_end      = tbl_last_i | wrap;
    // a pulse arriving in IDLE starts the drain at once so a same-cycle host request waits
    assign drain_go      = (viol_pend | viol_i) & ~irq_o;
    assign drv_done      = busy & rd_valid & ~rd_tag;
    assign drain_end     = (state == DONE_HOLD) |
                           ((state == RD_ADDR) & drv_done & ~rec_rcd_o[RCD_ILLCGT_BIT]);
    assign host_rvalid_o = rd_valid & rd_tag;
    assign host_rdata_o  = host_rvalid_o ? rd_data : host_rdata_q;

    always_comb begin
        state_n    = state;
        busy_n     = busy;
        host_gnt_o = 1'b0;
        cmd_valid  = 1'b0;
        cmd_we     = 1'b0;
        cmd_tag    = 1'b0;
        cmd_off    = '0;
        cmd_wdata  = '0;
        case (state)
            BOOT: begin
                cmd_valid = 1'b1;
                cmd_we    = 1'b1;
                cmd_off   = tbl_off_i;
                cmd_wdata = tbl_data_i;
                state_n   = boot_end ? IDLE : BOOT;
            end
            IDLE: state_n = drain_go ? RD_RCD : (host_req_i ? HOST : IDLE);
            HOST: begin
                host_gnt_o = 1'b1;
                cmd_valid  = 1'b1;
                cmd_we     = host_we_i;
                cmd_tag    = ~host_we_i;
                cmd_off    = host_off_i;
                cmd_wdata  = host_wdata_i;
                state_n    = IDLE;
            end
            RD_RCD, RD_ADDR: begin
                cmd_valid = ~busy;
                cmd_off   = ADDR_WIDTH'(state == RD_RCD ? IOPMP_RCD_OFF : IOPMP_RCD_ADDR_OFF);
                busy_n    = ~drv_done;
                state_n   = ~drv_done ? state :
                            (state == RD_RCD) ? RD_ADDR :
                            (rec_rcd_o[RCD_ILLCGT_BIT] ? CLR : IDLE);
            end
            CLR: begin
                cmd_valid = 1'b1;
                cmd_we    = 1'b1;
                cmd_off   = ADDR_WIDTH'(IOPMP_RCD_OFF);
                state_n   = DONE_HOLD;
            end
            DONE_HOLD: state_n = IDLE;
            default:   state_n = BOOT;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= BOOT;
            busy         <= 1'b0;
            tbl_idx_o    <= '0;
            boot_done_o  <= 1'b0;
            boot_err_o   <= 1'b0;
            viol_pend    <= 1'b0;
            irq_o        <= 1'b0;
            ovf_cnt_o    <= '0;
            rec_rcd_o    <= '0;
            rec_addr_o   <= '0;
            host_rdata_q <= '0;
        end else begin
            state        <= state_n;
            busy         <= busy_n;
            tbl_idx_o    <= (state == BOOT && !boot_end) ? tbl_idx_o + 1'b1 : tbl_idx_o;
            boot_done_o  <= boot_done_o | (state == BOOT && boot_end);
            boot_err_o   <= boot_err_o | (state == BOOT && wrap);
            viol_pend    <= drain_end ? 1'b0 : (viol_pend | (viol_i & ~irq_o));
            irq_o        <= (state == DONE_HOLD) | (irq_o & ~irq_ack_i);
            ovf_cnt_o    <= (irq_ack_i & irq_o) ? 8'd0 :
                            (viol_i & (irq_o | viol_pend) & (ovf_cnt_o != 8'hff)) ? ovf_cnt_o + 8'd1 :
                            ovf_cnt_o;
            rec_rcd_o    <= (state == RD_RCD && drv_done) ? rd_data[31:0] : rec_rcd_o;
            rec_addr_o   <= (state == RD_ADDR && drv_done) ? rd_data : rec_addr_o;
            host_rdata_q <= host_rdata_o;
        end
    end

    iopmp_cfg_port_drv #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .IOPMP_BASE(IOPMP_BASE)
    ) u_drv (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cmd_valid_i (cmd_valid),
        .cmd_we_i    (cmd_we),
        .cmd_tag_i   (cmd_tag),
        .cmd_off_i   (cmd_off),
        .cmd_wdata_i (cmd_wdata),
        .address_cfg (address_cfg),
        .en_cfg      (en_cfg),
        .we_cfg      (we_cfg),
        .wdata_cfg   (wdata_cfg),
        .rdata_cfg   (rdata_cfg),
        .rd_valid_o  (rd_valid),
        .rd_tag_o    (rd_tag),
        .rd_data_o   (rd_data)
    );
endmodule
